// File: rtl/cva5_config.sv
// Core-wide configuration constants shared by the writeback path.
package cva5_config;
   localparam int XLEN = 32;
   localparam int PHYS_REG_ADDR_W = 6;

   // Round-robin pointer width; a single requester still gets a 1-bit pointer.
   function automatic int WB_PTR_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/cva5_types.sv
// Shared datapath types for register-file writeback.
package cva5_types;
   import cva5_config::*;

   typedef logic [PHYS_REG_ADDR_W-1:0] phys_addr_t;

   typedef struct packed {
      logic                valid;
      phys_addr_t          phys_addr;
      logic [XLEN-1:0]     data;
   } commit_packet_t;
endpackage

// File: rtl/wb_round_robin_arbiter.sv
// Round-robin arbiter: search starts at ptr, first requester wins, ptr moves past the winner.
module wb_round_robin_arbiter
   import cva5_config::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDX_W = WB_PTR_W(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);
   logic [IDX_W-1:0] ptr;
   logic [IDX_W:0]   cand;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      idx         = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // ptr + k stays below 2*NUM_REQ, so one conditional subtract wraps it
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ))
            cand = cand - (IDX_W+1)'(NUM_REQ);
         idx = cand[IDX_W-1:0];
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant[idx]  = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (grant_valid)
         ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
   end
endmodule

// File: rtl/writeback_commit_arbiter.sv
// One register-file write port: per-unit one-entry buffers, round-robin pick,
// registered commit packet plus the matching inflight-clear.
module writeback_commit_arbiter
   import cva5_config::*;
   import cva5_types::*;
#(
   parameter int NUM_UNITS  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_UNITS-1:0]                 unit_valid,
   output logic [NUM_UNITS-1:0]                 unit_ready,
   input  phys_addr_t [NUM_UNITS-1:0]           unit_phys_addr,
   input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] unit_data,
   output commit_packet_t                       commit,
   output logic                                 inflight_commit,
   output phys_addr_t                           inflight_commit_addr
);
   localparam int IDX_W = WB_PTR_W(NUM_UNITS);

   logic [NUM_UNITS-1:0]                 full;
   logic [NUM_UNITS-1:0]                 grant;
   phys_addr_t [NUM_UNITS-1:0]           entry_addr;
   logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] entry_data;
   logic [IDX_W-1:0]                     grant_idx;
   logic                                 grant_valid;
   phys_addr_t                           addr_w;
   logic [DATA_WIDTH-1:0]                data_w;

   wb_round_robin_arbiter #(.NUM_REQ(NUM_UNITS)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (full),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Draining entry may be refilled in the same cycle; held open while in reset.
   assign unit_ready = ~full | grant | {NUM_UNITS{rst}};
   assign addr_w     = entry_addr[grant_idx];
   assign data_w     = entry_data[grant_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         full   <= '0;
         commit <= '0;
      end else begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            if (unit_valid[i] && unit_ready[i]) begin
               full[i]       <= 1'b1;
               entry_addr[i] <= unit_phys_addr[i];
               entry_data[i] <= unit_data[i];
            end else if (grant[i]) begin
               full[i] <= 1'b0;
            end
         end
         // Writes to physical register 0 drain silently.
         commit.valid     <= grant_valid && (addr_w != '0);
         commit.phys_addr <= addr_w;
         commit.data      <= XLEN'(data_w);
      end
   end

   assign inflight_commit      = commit.valid;
   assign inflight_commit_addr = commit.phys_addr;
endmodule

// File: tb/tb_writeback_commit_arbiter.sv
// Bench for writeback_commit_arbiter: directed table, corner sequences, random traffic vs. model.
module tb_writeback_commit_arbiter;
   import cva5_types::*;

   localparam int N = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         unit_valid;
   logic [N-1:0]         unit_ready;
   phys_addr_t [N-1:0]   unit_phys_addr;
   logic [N-1:0][31:0]   unit_data;
   commit_packet_t       commit;
   logic                 inflight_commit;
   phys_addr_t           inflight_commit_addr;

   writeback_commit_arbiter #(.NUM_UNITS(N), .DATA_WIDTH(32)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .unit_valid           (unit_valid),
      .unit_ready           (unit_ready),
      .unit_phys_addr       (unit_phys_addr),
      .unit_data            (unit_data),
      .commit               (commit),
      .inflight_commit      (inflight_commit),
      .inflight_commit_addr (inflight_commit_addr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // reference model: buffer contents, rotating priority, pending commit
   bit          m_full[N];
   int          m_addr[N];
   logic [31:0] m_data[N];
   int          m_ptr = 0;
   logic [N-1:0] m_rdy;
   bit          exp_v = 0;
   int          exp_a = 0;
   logic [31:0] exp_d = '0;

   typedef struct { int cyc; int addr; logic [31:0] data; } ent_t;
   ent_t cq[$];

   typedef struct { int u; int a; logic [31:0] d; int exp_n; int exp_ptr; } vec_t;
   vec_t tbl[5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic cycle();
      int win;
      @(negedge clk);
      win = -1;
      for (int k = 0; k < N; k++)
         if (win < 0 && m_full[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      for (int i = 0; i < N; i++)
         m_rdy[i] = !m_full[i] || (win == i) || rst;
      chk("unit_ready", unit_ready, m_rdy);
      chk("commit_valid", commit.valid, exp_v);
      chk("inflight_commit", inflight_commit, exp_v);
      if (exp_v) begin
         chk("commit_addr", commit.phys_addr, exp_a);
         chk("commit_data", commit.data, exp_d);
         chk("inflight_addr", inflight_commit_addr, exp_a);
      end
      chk("ptr", dut.u_arb.ptr, m_ptr);
      if (commit.valid === 1'b1)
         cq.push_back('{cyc, int'(commit.phys_addr), commit.data});
      if (rst) begin
         for (int i = 0; i < N; i++) m_full[i] = 0;
         m_ptr = 0;
         exp_v = 0;
      end else begin
         exp_v = (win >= 0) && (m_addr[win] != 0);
         if (win >= 0) begin
            exp_a = m_addr[win];
            exp_d = m_data[win];
            m_full[win] = 0;
            m_ptr = (win + 1) % N;
         end
         for (int i = 0; i < N; i++)
            if (unit_valid[i] && m_rdy[i]) begin
               m_full[i] = 1;
               m_addr[i] = int'(unit_phys_addr[i]);
               m_data[i] = unit_data[i];
            end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic offer(input int u, input int a, input logic [31:0] d);
      unit_valid[u[1:0]]     = 1'b1;
      unit_phys_addr[u[1:0]] = phys_addr_t'(a);
      unit_data[u[1:0]]      = d;
   endtask

   task automatic do_reset();
      unit_valid = '0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int n0, c0, o, t, cnt;
      rst = 1'b1;
      unit_valid = '0;
      unit_phys_addr = '0;
      unit_data = '0;
      for (int i = 0; i < N; i++) begin m_full[i] = 0; m_addr[i] = 0; m_data[i] = '0; end
      @(posedge clk);
      #1;
      chk("rst_commit", commit, '0);
      chk("rst_inflight", inflight_commit, 1'b0);
      chk("rst_ready", unit_ready, 4'hF);
      chk("rst_ptr", dut.u_arb.ptr, 0);
      cycle();
      rst = 1'b0;

      // single offers from idle
      tbl[0] = '{2, 5,  32'hDEADBEEF, 1, 3};
      tbl[1] = '{1, 0,  32'h00001234, 0, 2};
      tbl[2] = '{0, 63, 32'hFFFFFFFF, 1, 1};
      tbl[3] = '{3, 1,  32'h00000000, 1, 0};
      tbl[4] = '{1, 42, 32'h00005A5A, 1, 2};
      for (int v = 0; v < 5; v++) begin
         n0 = cq.size();
         c0 = cyc;
         offer(tbl[v].u, tbl[v].a, tbl[v].d);
         chk("tbl_ready_in", unit_ready[tbl[v].u[1:0]], 1'b1);
         cycle();
         unit_valid = '0;
         repeat (3) cycle();
         chk("tbl_ncommits", cq.size() - n0, tbl[v].exp_n);
         if (tbl[v].exp_n == 1 && cq.size() > n0) begin
            chk("tbl_cycle", cq[n0].cyc, c0 + 2);
            chk("tbl_addr", cq[n0].addr, tbl[v].a);
            chk("tbl_data", cq[n0].data, tbl[v].d);
         end
         chk("tbl_ptr", dut.u_arb.ptr, tbl[v].exp_ptr);
         chk("tbl_ready_out", unit_ready[tbl[v].u[1:0]], 1'b1);
      end

      // contention: all four at once, twice
      do_reset();
      for (int r = 0; r < 2; r++) begin
         n0 = cq.size();
         c0 = cyc;
         for (int u = 0; u < N; u++) offer(u, 10 + u, 32'(10 + u));
         cycle();
         unit_valid = '0;
         repeat (5) cycle();
         chk("cont_n", cq.size() - n0, 4);
         for (int k = 0; k < 4 && n0 + k < cq.size(); k++) begin
            chk("cont_addr", cq[n0+k].addr, 10 + k);
            chk("cont_data", cq[n0+k].data, 32'(10 + k));
            chk("cont_cycle", cq[n0+k].cyc, c0 + 2 + k);
         end
         chk("cont_ptr", dut.u_arb.ptr, 0);
      end

      // fairness: unit 0 streams, unit 3 cuts in once
      do_reset();
      n0 = cq.size();
      offer(0, 20, 32'h20);
      cycle();
      cycle();
      o = cyc;
      offer(3, 33, 32'h33);
      cycle();
      unit_valid[3] = 1'b0;
      repeat (4) cycle();
      unit_valid[0] = 1'b0;
      repeat (3) cycle();
      t = -1;
      for (int k = n0; k < cq.size(); k++) if (cq[k].addr == 33) t = cq[k].cyc;
      chk("fair_u3_seen", (t >= 0), 1'b1);
      chk("fair_u3_latency", (t >= 0 && t <= o + 3), 1'b1);
      cnt = 0;
      for (int k = n0; k < cq.size(); k++)
         if (cq[k].addr == 20 && cq[k].cyc >= o + 2 && cq[k].cyc <= t - 1) cnt++;
      chk("fair_u0_run", (cnt <= 1), 1'b1);

      // back-to-back refill of one unit
      n0 = cq.size();
      c0 = cyc;
      for (int k = 1; k <= 3; k++) begin
         offer(0, k, 32'(k * 100));
         chk("bp_ready", unit_ready[0], 1'b1);
         cycle();
      end
      unit_valid = '0;
      repeat (4) cycle();
      chk("bp_n", cq.size() - n0, 3);
      for (int k = 0; k < 3 && n0 + k < cq.size(); k++) begin
         chk("bp_addr", cq[n0+k].addr, k + 1);
         chk("bp_cycle", cq[n0+k].cyc, c0 + 2 + k);
      end

      // reset with all buffers full, before anything commits
      do_reset();
      for (int u = 0; u < N; u++) offer(u, 40 + u, 32'(40 + u));
      cycle();
      unit_valid = '0;
      n0 = cq.size();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("mid_rst_ready", unit_ready, 4'hF);
      chk("mid_rst_ptr", dut.u_arb.ptr, 0);
      repeat (3) cycle();
      chk("mid_rst_nocommit", cq.size() - n0, 0);
      c0 = cyc;
      offer(3, 7, 32'h77);
      cycle();
      unit_valid = '0;
      repeat (3) cycle();
      chk("mid_rst_new_n", cq.size() - n0, 1);
      if (cq.size() > n0) begin
         chk("mid_rst_new_cycle", cq[n0].cyc, c0 + 2);
         chk("mid_rst_new_addr", cq[n0].addr, 7);
      end

      // random traffic against the model, holding offers until accepted
      for (int it = 0; it < 600; it++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int u = 0; u < N; u++)
            if (!unit_valid[u] && $urandom_range(0, 1) == 1)
               offer(u, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)), $urandom);
         cycle();
         for (int u = 0; u < N; u++)
            if (unit_valid[u] && m_rdy[u]) unit_valid[u] = 1'b0;
      end
      rst = 1'b0;
      unit_valid = '0;
      repeat (6) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d actual=running required=done", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/writeback_commit_arbiter.md
# writeback_commit_arbiter

Producer side of one register-file write port. Collects results from `NUM_UNITS` execution units through a valid/ready handshake, buffers one result per unit, and picks one per cycle with a round-robin arbiter. It drives a registered `commit_packet_t` plus the matching inflight-clear notification into the register file. Instantiate it once per write port.

## Interface
- `NUM_UNITS`, default 4: units sharing this write port (≥1).
- `DATA_WIDTH`, default 32: result width; must be ≤ width of `commit_packet_t.data`.
- `clk`  in  1  clock.
- `rst`  in  1  reset. It is synchronous and active-high, with one clock.
- `unit_valid[NUM_UNITS]`  in  1 each  unit result offered.
- `unit_ready[NUM_UNITS]`  out  1 each  buffer can accept this cycle.
- `unit_phys_addr[NUM_UNITS]`  in  `phys_addr_t`  destination physical register.
- `unit_data[NUM_UNITS]`  in  `DATA_WIDTH`  result value.
- `commit`  out  `commit_packet_t`  registered write: valid, phys_addr, data.
- `inflight_commit`  out  1  clear the inflight bit. Equals `commit.valid`.
- `inflight_commit_addr`  out  `phys_addr_t`  equals `commit.phys_addr`.

## Operation
- Each unit has a one-entry buffer with fields `full`, `addr` and `data`.
- `unit_ready[i] = ~full[i] | grant[i]`. A buffer can be refilled in the same cycle it drains.
- A transfer occurs on `unit_valid[i] & unit_ready[i]`. It loads the buffer and sets `full`.
- Request vector: `req[i] = full[i]`.
- Round-robin arbitration:
  - Priority pointer `ptr` has width `max($clog2(NUM_UNITS),1)`.
  - Search starts at index `ptr` and increases, wrapping modulo `NUM_UNITS`.
  - The first requester wins: `grant` is one-hot, or zero if there are no requests.
- On any grant, `ptr <= winner+1`, wrapping to 0 after `NUM_UNITS-1`. With no grant, `ptr` holds.
- The granted buffer clears `full` unless it reloads in the same cycle.
- Output register, loaded every cycle:
  - `commit.valid <= |grant & (addr_w != 0)`.
  - `commit.phys_addr <= addr_w`.
  - `commit.data <= zero-extended data_w`.
- Results for physical register 0 are drained and discarded. `commit.valid` is never asserted for address 0.
- When `commit.valid=0`, the contents of `phys_addr` and `data` are don't-care. Verification checks them only when valid.
- `NUM_UNITS=1`: the arbiter degenerates to a pass-through and `ptr` stays 0.

## Timing
- Latency: a result accepted in cycle N commits at the earliest in cycle N+2. It lands in the buffer at the N→N+1 edge, is granted in N+1, and `commit` is valid in N+2.
- Throughput: one commit per cycle sustained. A single unit offering back-to-back results is accepted every cycle.
- `unit_ready` depends combinationally on `full` and `grant` only. It never depends on `unit_valid`.
- A unit must hold `unit_valid`, address and data stable until ready.
- Starvation bound: a full buffer is granted within `NUM_UNITS` cycles.
- Reset values:
  - All `full = 0` and `ptr = 0`.
  - `commit.valid = 0`, `phys_addr = 0`, `data = 0`.
  - `inflight_commit = 0` and `unit_ready` all 1 during and after reset.
- Reset mid-operation drops all buffered results; nothing commits on the cycle after reset.

## Structure
- `commit_packet_t` and `phys_addr_t` come from `cva5_types`; no new typedefs.
- Add constant `WB_PTR_W(n) = max($clog2(n),1)` to `cva5_config`.
- Sub-module `wb_round_robin_arbiter` (params `NUM_REQ`) with ports:
  - `clk`, `rst`
  - `req[NUM_REQ]`
  - `grant[NUM_REQ]` (one-hot)
  - `grant_idx`
  - `grant_valid`
- The top level holds the buffers and the output register.

## Test plan
- Single result: unit 2 offers addr 5, data 0xDEADBEEF in cycle 1.
  - `unit_ready[2]=1` in cycle 1.
  - Cycle 3: `commit={1,5,0xDEADBEEF}`, `inflight_commit=1`, `inflight_commit_addr=5`.
- Contention, all 4 units offering in one cycle, with addrs 10–13 and data equal to addr:
  - Commits in consecutive cycles in order 10, 11, 12, 13.
  - `ptr` ends at 0.
  - Each unit then offers again and the order repeats.
- Round-robin fairness:
  - Unit 0 offers continuously. Unit 3 offers once after unit 0's first grant.
  - Unit 3 commits no later than 2 cycles after its buffer fills.
  - Unit 0 is not granted twice in a row while unit 3 is full.
- Address zero: unit 1 offers addr 0, data 0x1234.
  - The buffer drains and `unit_ready[1]` returns to 1.
  - `commit.valid` and `inflight_commit` stay 0 throughout.
- Backpressure and refill: unit 0 offers 3 results on consecutive cycles (addrs 1, 2, 3) with no other traffic.
  - `unit_ready[0]` stays 1 throughout.
  - Commits of 1, 2, 3 appear on 3 consecutive cycles.
- Reset mid-flight: fill units 0–3, then assert `rst` for 1 cycle before any commit.
  - No commit follows reset.
  - All `unit_ready=1` and `ptr=0`.
  - A new offer from unit 3 commits 2 cycles later.
